branch_predict_resolve: RTL and testbench

Parametrised branch unit for the 3-stage pipeline: combines the XLEN-wide branch comparator with a bimodal branch history table (BHT) of 2-bit saturating counters. Fetch stage reads a prediction combinationally. Execute stage resolves the branch against that prediction. The block then issues a registered redirect/flush one cycle later and trains the BHT.

---
 rtl/bru_pkg.sv | 36 +++
 rtl/branch_compare.sv | 41 ++++
 rtl/branch_predict_resolve.sv | 124 ++++++++++++
 tb/tb_branch_predict_resolve.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bru_pkg.sv
// rtl/bru_pkg.sv - shared types, constants and counter helper for the branch unit
//
// Contents:
//   branch_type_e  branch comparison encodings (EQ, NE, NEVER, ALWAYS, LT, GE, LTU, GEU)
//   bht_ctr_t      2-bit saturating BHT counter
//   CTR_MAX/MIN    counter saturation limits
//   sat_update     one saturating counter step toward the resolved direction
package bru_pkg;

  typedef enum logic [2:0] {
    BR_EQ     = 3'd0,
    BR_NE     = 3'd1,
    BR_NEVER  = 3'd2,
    BR_ALWAYS = 3'd3,
    BR_LT     = 3'd4,
    BR_GE     = 3'd5,
    BR_LTU    = 3'd6,
    BR_GEU    = 3'd7
  } branch_type_e;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t CTR_MAX = 2'd3;
  localparam bht_ctr_t CTR_MIN = 2'd0;

  function automatic bht_ctr_t sat_update(input bht_ctr_t ctr, input logic taken);
    bht_ctr_t nxt;
    if (taken) begin
      nxt = (ctr == CTR_MAX) ? CTR_MAX : ctr + 2'd1;
    end else begin
      nxt = (ctr == CTR_MIN) ? CTR_MIN : ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_compare.sv
// rtl/branch_compare.sv - combinational branch condition evaluator
//
// Ports:
//   data1, data2  in  XLEN  comparator operands
//   branch_type   in  3     branch_type_e encoding
//   taken         out 1     resolved branch direction
module branch_compare
  import bru_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  input  logic [2:0]      branch_type,
  output logic            taken
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (data1 == data2);
  assign lt_s = ($signed(data1) < $signed(data2));
  assign lt_u = (data1 < data2);

  always_comb begin
    taken = 1'b0;
    case (branch_type_e'(branch_type))
      BR_EQ:     taken = eq;
      BR_NE:     taken = ~eq;
      BR_NEVER:  taken = 1'b0;
      BR_ALWAYS: taken = 1'b1;
      BR_LT:     taken = lt_s;
      BR_GE:     taken = ~lt_s;
      BR_LTU:    taken = lt_u;
      BR_GEU:    taken = ~lt_u;
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_resolve.sv
// rtl/branch_predict_resolve.sv - bimodal BHT predictor with execute-stage branch resolve
//
// Optional feature macro: BRU_PERF_CNT_EN (adds perf_branches / perf_mispredicts).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   if_pc             fetch PC; if_pred_taken is the MSB of its counter (combinational)
//   ex_valid, ex_pc   execute-stage instruction and its PC
//   ex_data1/2        comparator operands, ex_branch_type selects the condition
//   ex_target         computed taken target
//   ex_pred_taken     prediction carried from fetch, ex_pred_target its fetch target
//   redirect_valid    registered one-cycle flush/refetch pulse, redirect_pc its address
//   ex_taken          combinational resolved direction
//   perf_branches     (BRU_PERF_CNT_EN) saturating count of trained resolves
//   perf_mispredicts  (BRU_PERF_CNT_EN) saturating count of redirects
module branch_predict_resolve
  import bru_pkg::*;
#(
  parameter int       XLEN      = 32,
  parameter int       BHT_DEPTH = 64,
  parameter bht_ctr_t BHT_INIT  = 2'b01
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_pred_taken,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_data1,
  input  logic [XLEN-1:0] ex_data2,
  input  logic [2:0]      ex_branch_type,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            ex_taken
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispredicts
`endif
);

  localparam int              IDX_W   = $clog2(BHT_DEPTH);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  bht_ctr_t        bht [BHT_DEPTH];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             ex_v;
  logic             train;
  logic             mispredict;
  logic [XLEN-1:0]  next_pc;

  // Word-aligned PCs: bits [1:0] never select an entry, high bits alias.
  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];

  logic unused_if_pc_bits;
  assign unused_if_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

  // No bypass: a same-cycle write is only visible from the next cycle.
  assign if_pred_taken = bht[if_idx][1];

  branch_compare #(
    .XLEN (XLEN)
  ) u_compare (
    .data1       (ex_data1),
    .data2       (ex_data2),
    .branch_type (ex_branch_type),
    .taken       (ex_taken)
  );

  // The instruction sitting in execute while a redirect is out is wrong-path.
  assign ex_v  = ex_valid & ~redirect_valid;
  assign train = ex_v & (ex_branch_type != BR_NEVER);

  assign mispredict = ex_v & ((ex_taken != ex_pred_taken) |
                              (ex_taken & ex_pred_taken & (ex_target != ex_pred_target)));

  assign next_pc = ex_taken ? ex_target : ex_pc + PC_STEP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= mispredict;
      if (mispredict) begin
        redirect_pc <= next_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht[i] <= BHT_INIT;
      end
    end else if (train) begin
      bht[ex_idx] <= sat_update(bht[ex_idx], ex_taken);
    end
  end

`ifdef BRU_PERF_CNT_EN
  // Mispredicts are counted on detection, which is exactly the set of
  // cycles that launch a redirect pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (train && (perf_branches != '1)) begin
        perf_branches <= perf_branches + 32'd1;
      end
      if (mispredict && (perf_mispredicts != '1)) begin
        perf_mispredicts <= perf_mispredicts + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_predict_resolve.sv
// tb/tb_branch_predict_resolve.sv - directed self-checking bench for branch_predict_resolve
module tb_branch_predict_resolve;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_data1;
  logic [31:0] ex_data2;
  logic [2:0]  ex_branch_type;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ex_taken;
`ifdef BRU_PERF_CNT_EN
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  branch_predict_resolve #(
    .XLEN      (32),
    .BHT_DEPTH (64),
    .BHT_INIT  (2'b01)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_pc          (if_pc),
    .if_pred_taken  (if_pred_taken),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_data1       (ex_data1),
    .ex_data2       (ex_data2),
    .ex_branch_type (ex_branch_type),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ex_taken       (ex_taken)
`ifdef BRU_PERF_CNT_EN
    ,
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [2:0] t, input logic [31:0] pc,
                        input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] tgt,
                        input logic pt, input logic [31:0] ptgt);
    ex_valid       = v;
    ex_branch_type = t;
    ex_pc          = pc;
    ex_data1       = d1;
    ex_data2       = d2;
    ex_target      = tgt;
    ex_pred_taken  = pt;
    ex_pred_target = ptgt;
  endtask

  task automatic pred_at(input string tag, input logic [31:0] pc, input logic exp);
    if_pc = pc;
    #1;
    check(tag, {31'd0, if_pred_taken}, {31'd0, exp});
  endtask

  initial begin
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    exp_a = 8'b1001_1010;  // d1=-1, d2=1 : per type 7..0
    exp_b = 8'b1010_1001;  // d1=d2=5     : per type 7..0

    rst_n = 1'b0;
    if_pc = '0;
    set_ex(1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;

    // Reset state: every counter weakly not-taken, no redirect.
    for (int a = 0; a < 'h100; a += 4) begin
      pred_at("reset_pred", 32'(a), 1'b0);
    end
    check("reset_rv", {31'd0, redirect_valid}, 32'd0);
    check("reset_rpc", redirect_pc, 32'd0);

    // Comparator truth table, no state effect with ex_valid low.
    for (int t = 0; t < 8; t++) begin
      set_ex(1'b0, 3'(t), 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 32'h0);
      #1;
      check("cmp_neg", {31'd0, ex_taken}, {31'd0, exp_a[t]});
      set_ex(1'b0, 3'(t), 32'h0, 32'd5, 32'd5, 32'h0, 1'b0, 32'h0);
      #1;
      check("cmp_eq", {31'd0, ex_taken}, {31'd0, exp_b[t]});
    end

    // Signed LT taken, predicted not-taken -> redirect to target.
    set_ex(1'b1, 3'd4, 32'h10, 32'hFFFF_FFFF, 32'h1, 32'h80, 1'b0, 32'h0);
    #1;
    check("lt_taken", {31'd0, ex_taken}, 32'd1);
    tick();
    check("lt_rv", {31'd0, redirect_valid}, 32'd1);
    check("lt_rpc", redirect_pc, 32'h80);
    ex_valid = 1'b0;
    tick();
    check("lt_rv_drop", {31'd0, redirect_valid}, 32'd0);

    // Unsigned LT not-taken, predicted not-taken -> no redirect.
    set_ex(1'b1, 3'd6, 32'h14, 32'hFFFF_FFFF, 32'h1, 32'h80, 1'b0, 32'h0);
    #1;
    check("ltu_taken", {31'd0, ex_taken}, 32'd0);
    tick();
    check("ltu_rv", {31'd0, redirect_valid}, 32'd0);
    ex_valid = 1'b0;
    tick();

    // Training and saturation at 0x100 (index 0).
    set_ex(1'b1, 3'd0, 32'h100, 32'd9, 32'd9, 32'h180, 1'b0, 32'h0);
    pred_at("no_bypass", 32'h100, 1'b0);
    tick();
    check("tr1_rv", {31'd0, redirect_valid}, 32'd1);
    check("tr1_rpc", redirect_pc, 32'h180);
    pred_at("tr1_pred", 32'h100, 1'b1);
    ex_valid = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      set_ex(1'b1, 3'd0, 32'h100, 32'd9, 32'd9, 32'h180, 1'b1, 32'h180);
      tick();
      check("trn_rv", {31'd0, redirect_valid}, 32'd0);
      pred_at("trn_pred", 32'h100, 1'b1);
      ex_valid = 1'b0;
      tick();
    end
    set_ex(1'b1, 3'd0, 32'h100, 32'd1, 32'd2, 32'h180, 1'b1, 32'h180);
    tick();
    check("nt1_rv", {31'd0, redirect_valid}, 32'd1);
    check("nt1_rpc", redirect_pc, 32'h104);
    pred_at("nt1_pred", 32'h100, 1'b1);
    ex_valid = 1'b0;
    tick();
    set_ex(1'b1, 3'd0, 32'h100, 32'd1, 32'd2, 32'h180, 1'b1, 32'h180);
    tick();
    pred_at("nt2_pred", 32'h100, 1'b0);
    ex_valid = 1'b0;
    tick();

    // Wrong-path squash: back-to-back mispredicts give one pulse, no training.
    set_ex(1'b1, 3'd3, 32'h40, 32'h0, 32'h0, 32'h300, 1'b0, 32'h0);
    tick();
    check("sq_rv1", {31'd0, redirect_valid}, 32'd1);
    check("sq_rpc", redirect_pc, 32'h300);
    set_ex(1'b1, 3'd3, 32'h44, 32'h0, 32'h0, 32'h400, 1'b0, 32'h0);
    tick();
    check("sq_rv2", {31'd0, redirect_valid}, 32'd0);
    ex_valid = 1'b0;
    pred_at("sq_pred_n", 32'h40, 1'b1);
    pred_at("sq_pred_n1", 32'h44, 1'b0);
    tick();

    // Target mismatch and PC wrap-around.
    set_ex(1'b1, 3'd3, 32'h60, 32'h0, 32'h0, 32'h240, 1'b1, 32'h200);
    tick();
    check("tm_rv", {31'd0, redirect_valid}, 32'd1);
    check("tm_rpc", redirect_pc, 32'h240);
    ex_valid = 1'b0;
    tick();
    set_ex(1'b1, 3'd1, 32'hFFFF_FFFC, 32'd7, 32'd7, 32'h500, 1'b1, 32'h500);
    #1;
    check("wrap_taken", {31'd0, ex_taken}, 32'd0);
    tick();
    check("wrap_rv", {31'd0, redirect_valid}, 32'd1);
    check("wrap_rpc", redirect_pc, 32'h0);
    ex_valid = 1'b0;
    tick();

    // Type NEVER: can mispredict but never trains.
    set_ex(1'b1, 3'd3, 32'h80, 32'h0, 32'h0, 32'h90, 1'b1, 32'h90);
    tick();
    check("nv_pre_rv", {31'd0, redirect_valid}, 32'd0);
    set_ex(1'b1, 3'd2, 32'h80, 32'h0, 32'h0, 32'h90, 1'b1, 32'h90);
    tick();
    check("nv_rv", {31'd0, redirect_valid}, 32'd1);
    check("nv_rpc", redirect_pc, 32'h84);
    ex_valid = 1'b0;
    pred_at("nv_pred", 32'h80, 1'b1);
    tick();

    // Reset mid-operation discards a pending redirect and the table.
    set_ex(1'b1, 3'd3, 32'hC0, 32'h0, 32'h0, 32'h10, 1'b0, 32'h0);
    tick();
    check("mr_rv_pre", {31'd0, redirect_valid}, 32'd1);
    ex_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mr_rv", {31'd0, redirect_valid}, 32'd0);
    check("mr_rpc", redirect_pc, 32'h0);
    pred_at("mr_pred", 32'h100, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

`ifdef BRU_PERF_CNT_EN
    for (int i = 0; i < 10; i++) begin
      set_ex(1'b1, 3'd3, 32'h200 + 32'(i * 4), 32'h0, 32'h0, 32'h600, (i >= 3), 32'h600);
      tick();
      ex_valid = 1'b0;
      tick();
    end
    set_ex(1'b1, 3'd2, 32'h280, 32'h0, 32'h0, 32'h600, 1'b0, 32'h0);
    tick();
    ex_valid = 1'b0;
    tick();
    check("perf_br", perf_branches, 32'd10);
    check("perf_mp", perf_mispredicts, 32'd3);
    rst_n = 1'b0;
    #1;
    check("perf_br_rst", perf_branches, 32'd0);
    check("perf_mp_rst", perf_mispredicts, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
